// File: rtl/asynch_if_rx_if.sv
// asynch_if_rx_if: bundle of the asynchronous input pair, capture control and event-reader handshake
//
// Signals:
//   async_l, async_w  asynchronous interface bits (unsynchronised)
//   arm               enables event capture
//   rd_ready          reader accepts the head event
//   rd_valid          head event available
//   rd_data           head event {timestamp, w, l}
//   count             FIFO occupancy, 0..DEPTH
//   ovf               sticky overflow flag
//   clr_ovf           clears ovf
// Modports: master = receiver side (asynch_if_rx), slave = driver/reader side.
interface asynch_if_rx_if #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
);
    logic                     async_l;
    logic                     async_w;
    logic                     arm;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [TS_W+1:0]          rd_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;
    logic                     clr_ovf;

    modport master (
        input  async_l, async_w, arm, rd_ready, clr_ovf,
        output rd_valid, rd_data, count, ovf
    );

    modport slave (
        output async_l, async_w, arm, rd_ready, clr_ovf,
        input  rd_valid, rd_data, count, ovf
    );
endinterface

// File: rtl/asynch_if_rx.sv
// asynch_if_rx: synchronises the async {w,l} pair, logs every change as a timestamped event in a show-ahead FIFO
//
// Ports:
//   clk   single clock
//   rst   synchronous, active-high reset
//   bus   asynch_if_rx_if.master: async_l/async_w in, arm in, rd_ready/rd_valid/rd_data
//         reader handshake, count occupancy out, ovf sticky overflow out, clr_ovf in
// Optional: define ASYNCH_IF_RX_DEBOUNCE_EN to insert a per-bit stable-count filter
//           (DEBOUNCE cycles) between the synchroniser and the change detector.
module asynch_if_rx #(
    parameter int DEPTH       = 4,
    parameter int TS_W        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic            clk,
    input  logic            rst,
    asynch_if_rx_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = TS_W + 2;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("DEBOUNCE must be >= 1");
    end

    typedef enum logic {IDLE, ARMED} state_t;

    logic [SYNC_STAGES-1:0] sync_l;
    logic [SYNC_STAGES-1:0] sync_w;
    logic [1:0]             s_raw;
    logic [1:0]             s;
    logic [1:0]             last;
    logic [TS_W-1:0]        ts;
    state_t                 state;
    logic [DW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_ptr_n;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_n;
    logic                   rd_valid;
    logic [DW-1:0]          rd_data;
    logic [DW-1:0]          entry;
    logic                   ovf;
    logic                   change;
    logic                   pop;
    logic                   full;
    logic                   push;
    logic                   drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_l <= '0;
            sync_w <= '0;
        end else begin
            sync_l <= {sync_l[SYNC_STAGES-2:0], bus.async_l};
            sync_w <= {sync_w[SYNC_STAGES-2:0], bus.async_w};
        end
    end

    assign s_raw = {sync_w[SYNC_STAGES-1], sync_l[SYNC_STAGES-1]};

`ifdef ASYNCH_IF_RX_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE + 1);

    logic [1:0]     filt;
    logic [DBW-1:0] dcnt [2];

    // A bit is accepted once it has differed from the filtered value for DEBOUNCE consecutive cycles;
    // any return to the filtered value restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_raw[i] == filt[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DBW'(DEBOUNCE - 1)) begin
                    filt[i] <= s_raw[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign s = filt;
`else
    assign s = s_raw;
`endif

    always_comb begin
        change   = (state == ARMED) && (s != last);
        pop      = rd_valid && bus.rd_ready;
        full     = count == CW'(DEPTH);
        push     = change && (!full || pop);
        drop     = change && full && !pop;
        rd_ptr_n = rd_ptr + AW'(pop);
        count_n  = count + CW'(push) - CW'(pop);
        entry    = {ts, s};
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= '0;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= bus.arm ? ARMED : IDLE;
            // IDLE tracks s every cycle; ARMED only differs from s when a change is logged,
            // so last follows s in both states (also on a dropped event).
            last     <= s;
            ts       <= ts + 1'b1;
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            rd_valid <= count_n != '0;
            // Head is the entry being written when it lands at the new read pointer
            // (empty FIFO, or the last entry popped in the same cycle).
            if (count_n != '0) rd_data <= (push && (wr_ptr == rd_ptr_n)) ? entry : mem[rd_ptr_n];
            ovf      <= drop | (ovf & ~bus.clr_ovf);
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_data;
    assign bus.count    = count;
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_asynch_if_rx.sv
// tb_asynch_if_rx: directed self-checking bench for asynch_if_rx (DEPTH=4, TS_W=16, SYNC_STAGES=2, DEBOUNCE=3)
module tb_asynch_if_rx;
    localparam int SS = 2;
    localparam int DB = 3;
`ifdef ASYNCH_IF_RX_DEBOUNCE_EN
    localparam int OFF = SS + DB;
`else
    localparam int OFF = SS;
`endif
    localparam int LAT = OFF + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t;
    int   tt [5];

    asynch_if_rx_if #(.DEPTH(4), .TS_W(16)) bus ();

    asynch_if_rx #(.DEPTH(4), .TS_W(16), .SYNC_STAGES(SS), .DEBOUNCE(DB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference time base: value the timestamp counter should hold in the current cycle
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] ev(input int ts, input logic [1:0] wl);
        return {16'(ts + OFF), wl};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [17:0] exp);
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk(tag, 32'(bus.rd_data), 32'(exp));
        bus.rd_ready = 1'b1;
        step(1);
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.async_l = 1'b0;
        bus.async_w = 1'b0;
        bus.arm = 1'b0;
        bus.rd_ready = 1'b0;
        bus.clr_ovf = 1'b0;
        step(3);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        bus.arm = 1'b1;

        // single rising edge on l
        step(8);
        t = cyc;
        bus.async_l = 1'b1;
        step(LAT - 1);
        chk("first_pre_valid", 32'(bus.rd_valid), 32'd0);
        step(1);
        chk("first_valid", 32'(bus.rd_valid), 32'd1);
        chk("first_count", 32'(bus.count), 32'd1);
        chk("first_data", 32'(bus.rd_data), 32'(ev(t, 2'b01)));
        bus.rd_ready = 1'b1;
        step(1);
        bus.rd_ready = 1'b0;
        chk("first_pop_count", 32'(bus.count), 32'd0);
        chk("first_pop_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty_hold_data", 32'(bus.rd_data), 32'(ev(t, 2'b01)));
        bus.rd_ready = 1'b1;
        step(1);
        bus.rd_ready = 1'b0;
        chk("empty_ready_count", 32'(bus.count), 32'd0);

        // w then l, five cycles apart
        t = cyc;
        bus.async_l = 1'b0;
        step(LAT + 1);
        pop_chk("l_fall", ev(t, 2'b00));
        t = cyc;
        bus.async_w = 1'b1;
        step(5);
        bus.async_l = 1'b1;
        step(LAT + 1);
        chk("pair_count", 32'(bus.count), 32'd2);
        pop_chk("pair_w", ev(t, 2'b10));
        pop_chk("pair_l", ev(t + 5, 2'b11));
        chk("pair_drained", 32'(bus.count), 32'd0);

        // five toggles into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            tt[i] = cyc;
            bus.async_l = (i % 2 == 1);
            step(4);
        end
        step(LAT);
        chk("ovf_count", 32'(bus.count), 32'd4);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk("ovf_drain", ev(tt[i], {1'b1, 1'(i % 2)}));
        chk("ovf_drained", 32'(bus.count), 32'd0);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);
        bus.clr_ovf = 1'b1;
        step(1);
        bus.clr_ovf = 1'b0;
        chk("ovf_clear", 32'(bus.ovf), 32'd0);

        // full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            tt[i] = cyc;
            bus.async_l = (i % 2 == 0);
            step(4);
        end
        step(LAT);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ovf", 32'(bus.ovf), 32'd0);
        t = cyc;
        bus.async_w = 1'b0;
        step(OFF);
        bus.rd_ready = 1'b1;
        step(1);
        bus.rd_ready = 1'b0;
        chk("pushpop_count", 32'(bus.count), 32'd4);
        chk("pushpop_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 1; i < 4; i++) pop_chk("pushpop_drain", ev(tt[i], {1'b1, 1'(i % 2 == 0)}));
        pop_chk("pushpop_tail", ev(t, 2'b00));
        chk("pushpop_drained", 32'(bus.count), 32'd0);

        // toggles while disarmed are not logged; arming with static inputs logs nothing
        bus.arm = 1'b0;
        step(1);
        bus.async_l = 1'b1;
        step(4);
        bus.async_w = 1'b1;
        step(4);
        bus.async_l = 1'b0;
        step(LAT + 2);
        chk("disarm_count", 32'(bus.count), 32'd0);
        chk("disarm_valid", 32'(bus.rd_valid), 32'd0);
        bus.arm = 1'b1;
        step(6);
        chk("arm_static_count", 32'(bus.count), 32'd0);
        t = cyc;
        bus.async_l = 1'b1;
        step(LAT);
        chk("arm_first_count", 32'(bus.count), 32'd1);
        pop_chk("arm_first", ev(t, 2'b11));

`ifdef ASYNCH_IF_RX_DEBOUNCE_EN
        // pulse shorter than DEBOUNCE is filtered, longer pulse gives rise and fall
        bus.async_l = 1'b0;
        step(2);
        bus.async_l = 1'b1;
        step(12);
        chk("short_pulse_count", 32'(bus.count), 32'd0);
        t = cyc;
        bus.async_l = 1'b0;
        step(4);
        bus.async_l = 1'b1;
        step(LAT + 1);
        chk("long_pulse_count", 32'(bus.count), 32'd2);
        pop_chk("long_pulse_fall", ev(t, 2'b10));
        pop_chk("long_pulse_rise", ev(t + 4, 2'b11));
`endif

        // reset in the middle of a drain
        bus.arm = 1'b0;
        bus.async_l = 1'b0;
        bus.async_w = 1'b0;
        step(LAT + 4);
        bus.arm = 1'b1;
        step(2);
        for (int i = 0; i < 4; i++) begin
            tt[i] = cyc;
            bus.async_l = (i % 2 == 0);
            step(4);
        end
        step(LAT);
        chk("predrain_count", 32'(bus.count), 32'd4);
        pop_chk("predrain_head", ev(tt[0], 2'b01));
        chk("middrain_count", 32'(bus.count), 32'd3);
        bus.rd_ready = 1'b1;
        rst = 1'b1;
        step(1);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_valid", 32'(bus.rd_valid), 32'd0);
        chk("midrst_data", 32'(bus.rd_data), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        bus.rd_ready = 1'b0;
        bus.async_l = 1'b1;
        step(LAT);
        chk("ts_restart_count", 32'(bus.count), 32'd1);
        pop_chk("ts_restart", ev(0, 2'b01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
